// File: rtl/l1_coherence_agent.sv
// l1_coherence_agent: per-core MSI coherence agent for a direct-mapped,
// one-word-per-line L1 that sits upstream of bus_controller.
// Optional feature: define L1_COHERENCE_STATS_EN to add the saturating
// hit_count / miss_count / inval_count statistics outputs.
module l1_coherence_agent #(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              req_core,
  input  logic              grant,
  output logic [1:0]        bus_op_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [31:0]       snoop_data_out,
  output logic              snoop_hit_out,
  input  logic [1:0]        snoop_op_in,
  input  logic [ADDR_W-1:0] snoop_addr_in,
  input  logic [31:0]       fill_data_in,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_data
`ifdef L1_COHERENCE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       inval_count
`endif
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_W - 2 - IW;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  typedef enum logic [1:0] {LINE_I = 2'b00, LINE_S = 2'b01, LINE_M = 2'b10} lineState_e;
  typedef enum logic [1:0] {IDLE = 2'b00, WB = 2'b01, REQ = 2'b10} fsm_e;

  lineState_e        state_q [NUM_LINES];
  logic [TW-1:0]     tag_q   [NUM_LINES];
  logic [31:0]       data_q  [NUM_LINES];
  fsm_e              fsm_q;

  logic [IW-1:0]     reqIdx, snpIdx;
  logic [TW-1:0]     reqTag, snpTag;
  lineState_e        reqState;
  logic              reqHit, cpuDone, needBus, victimWb, snpHit, fillEn;
  logic              unusedSnoopLow;

  assign reqIdx         = cpu_addr[2 +: IW];
  assign reqTag         = cpu_addr[ADDR_W-1 -: TW];
  assign snpIdx         = snoop_addr_in[2 +: IW];
  assign snpTag         = snoop_addr_in[ADDR_W-1 -: TW];
  assign unusedSnoopLow = ^snoop_addr_in[1:0];

  // Lookup of the core's line and the snooped line, and the miss/victim decisions
  always_comb begin
    reqState = state_q[reqIdx];
    reqHit   = (reqState != LINE_I) && (tag_q[reqIdx] == reqTag);
    cpuDone  = (fsm_q == IDLE) && cpu_req && reqHit && (!cpu_we || reqState == LINE_M);
    needBus  = (fsm_q == IDLE) && cpu_req && !cpuDone;
    victimWb = (reqState == LINE_M) && (tag_q[reqIdx] != reqTag);
    snpHit   = (snoop_op_in != OP_NONE) && (state_q[snpIdx] != LINE_I) &&
               (tag_q[snpIdx] == snpTag);
    fillEn   = (fsm_q == REQ) && grant;
  end

  // Core, bus, writeback and snoop outputs decoded from the FSM state and lookup
  always_comb begin
    cpu_rdata      = (cpuDone && !cpu_we) ? data_q[reqIdx] : 32'h0;
    stall          = needBus || (fsm_q != IDLE);
    req_core       = (fsm_q == REQ);
    bus_addr_out   = (fsm_q == REQ) ? cpu_addr : '0;
    bus_op_out     = OP_NONE;
    if (fsm_q == REQ) begin
      if (!cpu_we)     bus_op_out = OP_RD;
      else if (reqHit) bus_op_out = OP_UPGR;
      else             bus_op_out = OP_RDX;
    end
    wb_valid       = (fsm_q == WB);
    wb_addr        = (fsm_q == WB) ? {tag_q[reqIdx], reqIdx, 2'b00} : '0;
    wb_data        = (fsm_q == WB) ? data_q[reqIdx] : 32'h0;
    snoop_hit_out  = snpHit;
    snoop_data_out = snpHit ? data_q[snpIdx] : 32'h0;
  end

  // Request FSM: detect a miss, optionally write back the victim, then hold the bus request until granted
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= IDLE;
    end else begin
      case (fsm_q)
        IDLE:    if (needBus) fsm_q <= victimWb ? WB : REQ;
        WB:      fsm_q <= REQ;
        REQ:     if (grant) fsm_q <= IDLE;
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Line MSI state: snoop downgrades first, then victim eviction, and a same-cycle fill overrides both
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) state_q[i] <= LINE_I;
    end else begin
      if (snpHit) begin
        if (snoop_op_in == OP_RD) begin
          if (state_q[snpIdx] == LINE_M) state_q[snpIdx] <= LINE_S;
        end else begin
          state_q[snpIdx] <= LINE_I;
        end
      end
      if (fsm_q == WB) state_q[reqIdx] <= LINE_I;
      if (fillEn) state_q[reqIdx] <= cpu_we ? LINE_M : LINE_S;
    end
  end

  // Tag and data arrays are not reset; a grant that coincides with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fillEn) begin
        tag_q[reqIdx] <= reqTag;
        if (cpu_we)                       data_q[reqIdx] <= cpu_wdata;
        else                              data_q[reqIdx] <= fill_data_in;
      end else if (cpuDone && cpu_we) begin
        data_q[reqIdx] <= cpu_wdata;
      end
    end
  end

`ifdef L1_COHERENCE_STATS_EN
  logic snpInval;
  assign snpInval = snpHit && (snoop_op_in != OP_RD) && !(fillEn && (snpIdx == reqIdx));

  // Saturating statistics counters for hits, misses and snoop invalidations
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count   <= 32'h0;
      miss_count  <= 32'h0;
      inval_count <= 32'h0;
    end else begin
      if (cpuDone && hit_count != 32'hFFFF_FFFF)     hit_count   <= hit_count + 32'h1;
      if (needBus && miss_count != 32'hFFFF_FFFF)    miss_count  <= miss_count + 32'h1;
      if (snpInval && inval_count != 32'hFFFF_FFFF)  inval_count <= inval_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_coherence_agent.sv
// tb_l1_coherence_agent: directed self-checking bench for l1_coherence_agent.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_l1_coherence_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, req_core, grant;
  logic [1:0]  bus_op_out;
  logic [31:0] bus_addr_out, snoop_data_out;
  logic        snoop_hit_out;
  logic [1:0]  snoop_op_in;
  logic [31:0] snoop_addr_in, fill_data_in;
  logic        wb_valid;
  logic [31:0] wb_addr, wb_data;
`ifdef L1_COHERENCE_STATS_EN
  logic [31:0] hit_count, miss_count, inval_count;
`endif

  int checks   = 0;
  int failures = 0;

  l1_coherence_agent #(.NUM_LINES(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .req_core(req_core), .grant(grant), .bus_op_out(bus_op_out), .bus_addr_out(bus_addr_out),
    .snoop_data_out(snoop_data_out), .snoop_hit_out(snoop_hit_out),
    .snoop_op_in(snoop_op_in), .snoop_addr_in(snoop_addr_in), .fill_data_in(fill_data_in),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef L1_COHERENCE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .inval_count(inval_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; grant = 1'b0; snoop_op_in = 2'b11; snoop_addr_in = 32'h100;
    fill_data_in = 32'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    step(); step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_stall", {31'b0, stall}, 32'h0);
    checkOutput("rst_req_core", {31'b0, req_core}, 32'h0);
    checkOutput("rst_bus_op", {30'b0, bus_op_out}, 32'h3);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("rst_snoop_hit", {31'b0, snoop_hit_out}, 32'h0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);

    // Load miss at 0x100 with immediate grant
    $display("[TB] load miss 0x100");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    checkOutput("ld_miss_stall", {31'b0, stall}, 32'h1);
    checkOutput("ld_miss_idle_noreq", {31'b0, req_core}, 32'h0);
    step();
    grant = 1'b1; fill_data_in = 32'hCAFE_0001; #1;
    checkOutput("ld_req_core", {31'b0, req_core}, 32'h1);
    checkOutput("ld_bus_op_rd", {30'b0, bus_op_out}, 32'h0);
    checkOutput("ld_bus_addr", bus_addr_out, 32'h100);
    step();
    grant = 1'b0; #1;
    checkOutput("ld_fill_stall", {31'b0, stall}, 32'h0);
    checkOutput("ld_fill_rdata", cpu_rdata, 32'hCAFE_0001);
    checkOutput("ld_fill_bus_op", {30'b0, bus_op_out}, 32'h3);

    // Store to the shared line requires BusUpgr and keeps the line data
    $display("[TB] store upgrade 0x100");
    applyStimulus(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    checkOutput("st_s_stall", {31'b0, stall}, 32'h1);
    step();
    checkOutput("st_bus_op_upgr", {30'b0, bus_op_out}, 32'h1);
    grant = 1'b1; fill_data_in = 32'h1111_1111; #1;
    step();
    grant = 1'b0; #1;
    checkOutput("st_m_hit_stall", {31'b0, stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0);
    snoop_op_in = 2'b00; snoop_addr_in = 32'h300; #1;
    checkOutput("snp_other_tag_hit", {31'b0, snoop_hit_out}, 32'h0);
    snoop_addr_in = 32'h100; #1;
    checkOutput("snp_rd_hit", {31'b0, snoop_hit_out}, 32'h1);
    checkOutput("snp_rd_data", snoop_data_out, 32'hDEAD_BEEF);
    step();
    snoop_op_in = 2'b11; #1;
    checkOutput("snp_none_hit", {31'b0, snoop_hit_out}, 32'h0);

    // Line is now S: a store stalls and issues BusUpgr; a BusRdX snoop converts it to BusRdX
    $display("[TB] upgrade lost to snoop");
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h1234_5678);
    checkOutput("after_snp_s_stall", {31'b0, stall}, 32'h1);
    step();
    checkOutput("pend_upgr_op", {30'b0, bus_op_out}, 32'h1);
    snoop_op_in = 2'b10; snoop_addr_in = 32'h100; #1;
    checkOutput("snp_rdx_hit", {31'b0, snoop_hit_out}, 32'h1);
    step();
    snoop_op_in = 2'b11; #1;
    checkOutput("upgr_to_rdx_op", {30'b0, bus_op_out}, 32'h2);
    checkOutput("upgr_to_rdx_req", {31'b0, req_core}, 32'h1);
    grant = 1'b1; fill_data_in = 32'h5555_5555; #1;
    step();
    grant = 1'b0; #1;
    checkOutput("rdx_m_stall", {31'b0, stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    checkOutput("rdx_merge_rdata", cpu_rdata, 32'h1234_5678);

    // Conflicting load to 0x1100 evicts the modified 0x100 line
    $display("[TB] modified victim writeback");
    applyStimulus(1'b1, 1'b0, 32'h1100, 32'h0);
    checkOutput("wb_detect_stall", {31'b0, stall}, 32'h1);
    step();
    checkOutput("wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("wb_addr", wb_addr, 32'h100);
    checkOutput("wb_data", wb_data, 32'h1234_5678);
    checkOutput("wb_no_req", {31'b0, req_core}, 32'h0);
    step();
    checkOutput("wb_done_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("wb_req_op", {30'b0, bus_op_out}, 32'h0);
    checkOutput("wb_req_addr", bus_addr_out, 32'h1100);
    grant = 1'b1; fill_data_in = 32'hA5A5_A5A5; #1;
    step();
    grant = 1'b0; #1;
    checkOutput("wb_fill_rdata", cpu_rdata, 32'hA5A5_A5A5);
    checkOutput("wb_fill_stall", {31'b0, stall}, 32'h0);

    // Shared victim, grant withheld for 5 cycles
    $display("[TB] grant withheld");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    checkOutput("s_victim_stall", {31'b0, stall}, 32'h1);
    step();
    checkOutput("s_victim_no_wb", {31'b0, wb_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_req_%0d", i), {31'b0, req_core}, 32'h1);
      checkOutput($sformatf("hold_stall_%0d", i), {31'b0, stall}, 32'h1);
      checkOutput($sformatf("hold_addr_%0d", i), bus_addr_out, 32'h100);
      step();
    end
    grant = 1'b1; fill_data_in = 32'h0BAD_F00D; #1;
    step();
    grant = 1'b0; #1;
    checkOutput("hold_fill_rdata", cpu_rdata, 32'h0BAD_F00D);

    // Reset while requesting: request drops, no fill, every line misses
    $display("[TB] reset in REQ");
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0);
    step();
    checkOutput("pre_rst_req", {31'b0, req_core}, 32'h1);
    reset = 1'b1; grant = 1'b1; fill_data_in = 32'hFFFF_FFFF; cpu_req = 1'b0; #1;
    step();
    reset = 1'b0; grant = 1'b0; #1;
    checkOutput("post_rst_req", {31'b0, req_core}, 32'h0);
    checkOutput("post_rst_bus_op", {30'b0, bus_op_out}, 32'h3);
    checkOutput("post_rst_stall", {31'b0, stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    checkOutput("post_rst_miss_100", {31'b0, stall}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0);
    checkOutput("post_rst_miss_200", {31'b0, stall}, 32'h1);
    checkOutput("post_rst_rdata", cpu_rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
